wbm_cmd_engine: RTL and testbench
=================================

Name: wbm_cmd_engine

Overview:
- Parametrised WISHBONE classic master that turns a valid/ready command stream into single WB read/write cycles and returns one response per command.
- Successor to the constant-zero bus terminator: an idle, unused instance drives an identical quiet bus (cyc/stb/we/adr/dat/sel all 0).
- Adds real cycles, err handling and a bus-hang timeout.
- Sits between a control source (UART/PCIe bridge, sequencer) and a WB interconnect host port.

Parameters:
- ADDRESS_WIDTH, 16, width of wb_adr_o and cmd_adr_i.
- DATA_WIDTH, 32, data width; must be a multiple of 8; sel width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 255, cycles in CYCLE before abort; 0 disables the timeout.
- MAX_RETRY, 3, retry limit; used only with WBM_CMD_RETRY_EN.

Ports:
- clk_i  in  1  single clock.
- rst_n_i  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  engine accepts command.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_adr_i  in  ADDRESS_WIDTH  address.
- cmd_dat_i  in  DATA_WIDTH  write data.
- cmd_sel_i  in  DATA_WIDTH/8  byte selects.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  response consumed.
- rsp_dat_o  out  DATA_WIDTH  read data.
- rsp_status_o  out  2  00 ACK, 01 ERR, 10 TIMEOUT, 11 RETRY_EXHAUSTED.
- busy_o  out  1  high in any state other than IDLE.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1  WB controls.
- wb_adr_o  out  ADDRESS_WIDTH  WB address.
- wb_dat_o  out  DATA_WIDTH  WB write data.
- wb_sel_o  out  DATA_WIDTH/8  WB byte selects.
- wb_dat_i  in  DATA_WIDTH  WB read data.
- wb_ack_i, wb_err_i, wb_rty_i  in  1  WB terminations.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_n_i is asynchronous, active-low; all state and outputs clear immediately.
- Reset values: state IDLE; cmd_ready_o=1 after release; every other output 0, including rsp_dat_o and rsp_status_o.
- Registered outputs; no combinational path from any input to any output.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i & cmd_ready_o, latch we/adr/dat/sel and go to CYCLE.
  - wb_cyc_o and wb_stb_o rise on the next clock edge, so latency is 1 cycle from the accept edge.
- CYCLE:
  - cyc, stb, we, adr, dat and sel are held stable.
  - A timeout counter increments each cycle. It clears on entry to CYCLE.
  - On the first edge where a termination or timeout is seen:
    - cyc and stb drop on that edge.
    - rsp_status_o is latched.
    - For a read with ack, wb_dat_i is captured into rsp_dat_o.
    - For writes, err or timeout, rsp_dat_o=0.
    - Go to RESP.
  - Priority when terminations coincide: ack > err > rty > timeout.
  - Timeout fires when the counter equals TIMEOUT_CYCLES - 1 with no termination, i.e. after exactly TIMEOUT_CYCLES cycles with stb high.
  - Without WBM_CMD_RETRY_EN, rty_i is ignored.
- RESP:
  - rsp_valid_o=1; data and status are held until rsp_valid_o & rsp_ready_i, then go to IDLE.
  - cmd_ready_o=0 throughout RESP.
  - Peak throughput: one command per 3 cycles with ack on the first stb cycle and rsp_ready_i tied high.
- Drive rules:
  - wb_we_o, wb_adr_o, wb_dat_o and wb_sel_o are driven 0 whenever wb_cyc_o=0.
  - cmd_* inputs are ignored outside IDLE.
- Reset mid-cycle: cyc/stb drop asynchronously; no response is produced for the in-flight command.
- Terminations arriving while cyc=0 are ignored.

Optional Feature:
- Macro: WBM_CMD_RETRY_EN.
- Defined:
  - rty_i (with no ack/err) ends the current cycle; cyc drops for exactly 1 idle cycle, then the same cycle is re-issued.
  - The timeout counter clears on each re-issue.
  - A retry counter (width $clog2(MAX_RETRY+1)) clears on each command accept and increments on each rty.
  - The rty that would make the count exceed MAX_RETRY instead goes to RESP with status 11.
- Undefined: rty_i is unused, no retry counter exists, and status 11 is never produced.

Test Plan:
- Read, ack on 2nd stb cycle, wb_dat_i=0xDEADBEEF, adr 0x1234 -> cyc high exactly 2 cycles, adr=0x1234, we=0; rsp_status_o=00, rsp_dat_o=0xDEADBEEF; cyc/adr=0 after.
- Write, dat 0xA5A5A5A5, sel 4'b0011, ack 1st cycle, rsp_ready_i held low 5 cycles -> rsp_valid_o held 5 cycles with stable data/status; cmd_ready_o=0 until response taken; rsp_dat_o=0.
- Read with err_i and ack_i asserted together -> status 00; err_i alone -> status 01, rsp_dat_o=0.
- TIMEOUT_CYCLES=8, slave never acks -> stb high exactly 8 cycles, then status 10. Same with TIMEOUT_CYCLES=0 -> cyc held 1000 cycles, no response.
- Assert rst_n_i low while cyc is high -> all outputs 0 asynchronously; after release, a new read completes normally.
- WBM_CMD_RETRY_EN with MAX_RETRY=3:
  - rty on every attempt -> 4 bus cycles, each separated by 1 idle cycle, then status 11.
  - rty twice, then ack -> status 00.

Source files
------------

// File: rtl/wbm_cmd_engine.sv
// WISHBONE classic master: one valid/ready command becomes one WB read/write cycle and one response.
// Latency: cyc/stb rise 1 cycle after the accept edge; the response is registered on the terminating edge.
// Backpressure: cmd_ready_o is low from accept until the response is consumed (rsp_valid_o & rsp_ready_i).
// Optional retry on wb_rty_i is enabled by defining WBM_CMD_RETRY_EN.
module wbm_cmd_engine #(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_RETRY      = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_we_i,
  input  logic [ADDRESS_WIDTH-1:0]  cmd_adr_i,
  input  logic [DATA_WIDTH-1:0]     cmd_dat_i,
  input  logic [DATA_WIDTH/8-1:0]   cmd_sel_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [DATA_WIDTH-1:0]     rsp_dat_o,
  output logic [1:0]                rsp_status_o,
  output logic                      busy_o,
  output logic                      wb_cyc_o,
  output logic                      wb_stb_o,
  output logic                      wb_we_o,
  output logic [ADDRESS_WIDTH-1:0]  wb_adr_o,
  output logic [DATA_WIDTH-1:0]     wb_dat_o,
  output logic [DATA_WIDTH/8-1:0]   wb_sel_o,
  input  logic [DATA_WIDTH-1:0]     wb_dat_i,
  input  logic                      wb_ack_i,
  input  logic                      wb_err_i,
  input  logic                      wb_rty_i
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int TO_WIDTH  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [1:0] STATUS_ACK     = 2'b00;
  localparam logic [1:0] STATUS_ERR     = 2'b01;
  localparam logic [1:0] STATUS_TIMEOUT = 2'b10;
  localparam logic [1:0] STATUS_RETRY   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CYCLE = 2'd1,
    ST_GAP   = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic                       accept;
  logic                       timeout_hit;
  logic [1:0]                 status_d;
  logic                       retry_take;
  logic [TO_WIDTH-1:0]        to_cnt_q;

  // latched command, kept across retries while the bus itself is driven quiet
  logic                       we_q;
  logic [ADDRESS_WIDTH-1:0]   adr_q;
  logic [DATA_WIDTH-1:0]      dat_q;
  logic [SEL_WIDTH-1:0]       sel_q;

  // next values of the registered outputs
  logic                       in_cycle_d;
  logic                       we_d;
  logic [ADDRESS_WIDTH-1:0]   adr_d;
  logic [DATA_WIDTH-1:0]      dat_d;
  logic [SEL_WIDTH-1:0]       sel_d;
  logic [DATA_WIDTH-1:0]      rsp_dat_d;

`ifdef WBM_CMD_RETRY_EN
  localparam int RTY_WIDTH = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RTY_WIDTH-1:0]       rty_cnt_q;
  logic                       rty_limit;
  assign rty_limit = (rty_cnt_q == RTY_WIDTH'(MAX_RETRY));
`else
  localparam int unused_max_retry = MAX_RETRY;
  logic                       unused_rty;
  assign unused_rty = wb_rty_i;
`endif

  assign accept      = (state_q == ST_IDLE) && cmd_valid_i && cmd_ready_o;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (to_cnt_q == TO_WIDTH'(TIMEOUT_CYCLES - 1));

  // state, command latch, counters and all registered outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      to_cnt_q     <= '0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
      cmd_ready_o  <= 1'b0;
      busy_o       <= 1'b0;
      rsp_valid_o  <= 1'b0;
      rsp_dat_o    <= '0;
      rsp_status_o <= 2'b00;
      wb_cyc_o     <= 1'b0;
      wb_stb_o     <= 1'b0;
      wb_we_o      <= 1'b0;
      wb_adr_o     <= '0;
      wb_dat_o     <= '0;
      wb_sel_o     <= '0;
`ifdef WBM_CMD_RETRY_EN
      rty_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_o <= (state_d == ST_IDLE);
      busy_o      <= (state_d != ST_IDLE);
      rsp_valid_o <= (state_d == ST_RESP);
      wb_cyc_o    <= in_cycle_d;
      wb_stb_o    <= in_cycle_d;
      wb_we_o     <= we_d;
      wb_adr_o    <= adr_d;
      wb_dat_o    <= dat_d;
      wb_sel_o    <= sel_d;
      if (accept) begin
        we_q  <= cmd_we_i;
        adr_q <= cmd_adr_i;
        dat_q <= cmd_dat_i;
        sel_q <= cmd_sel_i;
      end
      if (in_cycle_d && (state_q != ST_CYCLE)) begin
        to_cnt_q <= '0;
      end else if ((state_q == ST_CYCLE) && (TIMEOUT_CYCLES != 0)) begin
        to_cnt_q <= to_cnt_q + TO_WIDTH'(1);
      end
      if ((state_q == ST_CYCLE) && (state_d == ST_RESP)) begin
        rsp_status_o <= status_d;
        rsp_dat_o    <= rsp_dat_d;
      end
`ifdef WBM_CMD_RETRY_EN
      if (accept) begin
        rty_cnt_q <= '0;
      end else if (retry_take) begin
        rty_cnt_q <= rty_cnt_q + RTY_WIDTH'(1);
      end
`endif
    end
  end

  // next state and termination status; ack > err > rty > timeout
  always_comb begin
    state_d    = state_q;
    status_d   = STATUS_ACK;
    retry_take = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_CYCLE;
      end
      ST_CYCLE: begin
        if (wb_ack_i) begin
          state_d  = ST_RESP;
          status_d = STATUS_ACK;
        end else if (wb_err_i) begin
          state_d  = ST_RESP;
          status_d = STATUS_ERR;
`ifdef WBM_CMD_RETRY_EN
        end else if (wb_rty_i) begin
          if (rty_limit) begin
            state_d  = ST_RESP;
            status_d = STATUS_RETRY;
          end else begin
            state_d    = ST_GAP;
            retry_take = 1'b1;
          end
`endif
        end else if (timeout_hit) begin
          state_d  = ST_RESP;
          status_d = STATUS_TIMEOUT;
        end
      end
      ST_GAP: begin
        state_d = ST_CYCLE;
      end
      ST_RESP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // next bus drive and response data; bus fields read zero whenever cyc is low
  always_comb begin
    in_cycle_d = (state_d == ST_CYCLE);
    we_d       = in_cycle_d && (accept ? cmd_we_i : we_q);
    adr_d      = in_cycle_d ? (accept ? cmd_adr_i : adr_q) : '0;
    dat_d      = in_cycle_d ? (accept ? cmd_dat_i : dat_q) : '0;
    sel_d      = in_cycle_d ? (accept ? cmd_sel_i : sel_q) : '0;
    rsp_dat_d  = ((status_d == STATUS_ACK) && !we_q) ? wb_dat_i : '0;
  end

endmodule

// File: tb/tb_wbm_cmd_engine.sv
module tb_wbm_cmd_engine;
  localparam int T    = 8;
  localparam int MAXR = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [15:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, busy;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_status;
  logic        wb_cyc, wb_stb, wb_we;
  logic [15:0] wb_adr;
  logic [31:0] wb_wdat, wb_rdat;
  logic [3:0]  wb_sel;
  logic        wb_ack, wb_err, wb_rty;

  // second instance with the timeout disabled; its slave never answers
  logic        z_cmd_valid, z_cmd_ready, z_rsp_valid, z_busy;
  logic [31:0] z_rsp_dat, z_wdat;
  logic [1:0]  z_rsp_status;
  logic        z_cyc, z_stb, z_we;
  logic [15:0] z_adr;
  logic [3:0]  z_sel;
  logic        z_zero;

  wbm_cmd_engine #(.ADDRESS_WIDTH(16), .DATA_WIDTH(32), .TIMEOUT_CYCLES(T), .MAX_RETRY(MAXR)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
    .rsp_status_o(rsp_status), .busy_o(busy),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_adr_o(wb_adr),
    .wb_dat_o(wb_wdat), .wb_sel_o(wb_sel), .wb_dat_i(wb_rdat),
    .wb_ack_i(wb_ack), .wb_err_i(wb_err), .wb_rty_i(wb_rty)
  );

  wbm_cmd_engine #(.ADDRESS_WIDTH(16), .DATA_WIDTH(32), .TIMEOUT_CYCLES(0), .MAX_RETRY(MAXR)) dut_nto (
    .clk_i(clk), .rst_n_i(rst_n),
    .cmd_valid_i(z_cmd_valid), .cmd_ready_o(z_cmd_ready), .cmd_we_i(z_zero),
    .cmd_adr_i(16'h0042), .cmd_dat_i(32'h0), .cmd_sel_i(4'hF),
    .rsp_valid_o(z_rsp_valid), .rsp_ready_i(1'b1), .rsp_dat_o(z_rsp_dat),
    .rsp_status_o(z_rsp_status), .busy_o(z_busy),
    .wb_cyc_o(z_cyc), .wb_stb_o(z_stb), .wb_we_o(z_we), .wb_adr_o(z_adr),
    .wb_dat_o(z_wdat), .wb_sel_o(z_sel), .wb_dat_i(32'h0),
    .wb_ack_i(z_zero), .wb_err_i(z_zero), .wb_rty_i(z_zero)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // term codes: 0 none, 1 ack, 2 err, 3 rty, 4 ack+err
  typedef struct {
    logic        we;
    logic [15:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          term;
    int          delay;
    logic [31:0] rdat;
    int          rdy_wait;
    logic [1:0]  est;
    logic [31:0] edat;
    int          ecyc;
  } vec_t;

  vec_t tv[8];

  // reference: what a WB master must report for a given slave behaviour
  function automatic void model(input logic we, input int term, input int delay, input int n_rty,
                                input logic [31:0] rdat, output logic [1:0] st, output logic [31:0] d,
                                output int cyc, output int att);
    bit ack;
    bit err;
    ack = (term == 1) || (term == 4);
    err = (term == 2) || (term == 4);
    att = n_rty + 1;
    st  = 2'b10;
    d   = 32'h0;
    cyc = T;
`ifdef WBM_CMD_RETRY_EN
    if (n_rty > MAXR) begin
      att = MAXR + 1;
      st  = 2'b11;
      cyc = 1;
      return;
    end
`endif
    if (delay < T && (ack || err)) begin
      cyc = delay + 1;
      st  = ack ? 2'b00 : 2'b01;
      if (!we && ack) d = rdat;
    end
  endfunction

  // issue one command, act as the slave, then consume the response
  task automatic run_cmd(input string tag, input logic we, input logic [15:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int term, input int delay, input int n_rty,
                         input logic [31:0] rdat, input int rdy_wait,
                         input logic [1:0] est, input logic [31:0] edat, input int ecyc, input int eatt);
    int ncyc;
    int att;
    int gap;
    logic prev_cyc;
    bit bus_bad;
    bit gap_bad;
    bit hold_bad;
    bit got;
    logic [1:0]  st;
    logic [31:0] rd;
    ncyc = 0; att = 0; gap = 0; prev_cyc = 1'b0;
    bus_bad = 0; gap_bad = 0; hold_bad = 0; got = 0;
    @(negedge clk);
    for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
    check({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    wb_rdat = rdat;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_we = 1'($urandom); cmd_adr = 16'($urandom); cmd_dat = $urandom; cmd_sel = 4'($urandom);
    for (int i = 0; i < 200; i++) begin
      if (wb_cyc) begin
        if (!prev_cyc) begin
          att++;
          ncyc = 0;
          if (att > 1 && gap != 1) gap_bad = 1;
          gap = 0;
        end
        ncyc++;
        if (!wb_stb || wb_we !== we || wb_adr !== adr || wb_wdat !== dat || wb_sel !== sel) bus_bad = 1;
        wb_ack = 1'b0; wb_err = 1'b0; wb_rty = 1'b0;
        if (att <= n_rty) begin
          if (ncyc == 1) wb_rty = 1'b1;
        end else if (ncyc == delay + 1) begin
          wb_ack = (term == 1) || (term == 4);
          wb_err = (term == 2) || (term == 4);
          wb_rty = (term == 3);
        end
      end else begin
        if (wb_stb || wb_we || wb_adr != 0 || wb_wdat != 0 || wb_sel != 0) bus_bad = 1;
        if (att > 0) gap++;
        wb_ack = 1'b0; wb_err = 1'b0; wb_rty = 1'b0;
      end
      prev_cyc = wb_cyc;
      if (rsp_valid) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    wb_ack = 1'b0; wb_err = 1'b0; wb_rty = 1'b0;
    check({tag, "_rsp_seen"}, got, 1'b1);
    st = rsp_status;
    rd = rsp_dat;
    check({tag, "_status"}, st, est);
    check({tag, "_rsp_dat"}, rd, edat);
    check({tag, "_stb_cycles"}, ncyc, ecyc);
    check({tag, "_attempts"}, att, eatt);
    check({tag, "_bus_drive"}, bus_bad, 1'b0);
    if (eatt > 1) check({tag, "_retry_gap"}, gap_bad, 1'b0);
    for (int k = 0; k < rdy_wait; k++) begin
      if (!rsp_valid || rsp_status !== st || rsp_dat !== rd || cmd_ready || !busy) hold_bad = 1;
      @(negedge clk);
    end
    if (rdy_wait > 0) check({tag, "_rsp_hold"}, hold_bad, 1'b0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_after"}, {rsp_valid, cmd_ready, busy, wb_cyc, wb_adr}, {1'b0, 1'b1, 1'b0, 1'b0, 16'h0});
  endtask

  initial begin
    logic [1:0]  est;
    logic [31:0] edat;
    int          ecyc, eatt, term, acc, zc, zr;
    logic        we;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b0; wb_rdat = '0; wb_ack = 1'b0; wb_err = 1'b0; wb_rty = 1'b0;
    z_cmd_valid = 1'b0; z_zero = 1'b0;

    tv[0] = '{1'b0, 16'h1234, 32'h0, 4'hF, 1, 1, 32'hDEADBEEF, 0, 2'b00, 32'hDEADBEEF, 2};
    tv[1] = '{1'b1, 16'h0010, 32'hA5A5A5A5, 4'b0011, 1, 0, 32'h99999999, 5, 2'b00, 32'h0, 1};
    tv[2] = '{1'b0, 16'h2000, 32'h0, 4'hF, 4, 0, 32'h12345678, 0, 2'b00, 32'h12345678, 1};
    tv[3] = '{1'b0, 16'h2004, 32'h0, 4'hF, 2, 2, 32'hFFFF0000, 1, 2'b01, 32'h0, 3};
    tv[4] = '{1'b0, 16'h3000, 32'h0, 4'hF, 0, 0, 32'h87654321, 0, 2'b10, 32'h0, 8};
    tv[5] = '{1'b1, 16'h3004, 32'h11223344, 4'hF, 2, 7, 32'h0, 2, 2'b01, 32'h0, 8};
    tv[6] = '{1'b0, 16'h3008, 32'h0, 4'hC, 1, 7, 32'hCAFEF00D, 0, 2'b00, 32'hCAFEF00D, 8};
    tv[7] = '{1'b1, 16'h300C, 32'h00000055, 4'h1, 1, 8, 32'h0, 0, 2'b10, 32'h0, 8};

    #1;
    check("reset_outputs",
          {wb_cyc, wb_stb, wb_we, wb_adr, wb_wdat, wb_sel, rsp_valid, rsp_dat, rsp_status, busy, cmd_ready},
          '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {cmd_ready, busy, wb_cyc, rsp_valid}, 4'b1000);

    for (int i = 0; i < 8; i++)
      run_cmd($sformatf("vec%0d", i), tv[i].we, tv[i].adr, tv[i].dat, tv[i].sel, tv[i].term,
              tv[i].delay, 0, tv[i].rdat, tv[i].rdy_wait, tv[i].est, tv[i].edat, tv[i].ecyc, 1);

    for (int i = 0; i < 30; i++) begin
      we = 1'($urandom);
      case ($urandom_range(0, 4))
        0: term = 0;
        1: term = 1;
        2: term = 2;
`ifdef WBM_CMD_RETRY_EN
        3: term = 1;
`else
        3: term = 3;
`endif
        default: term = 4;
      endcase
      model(we, term, $urandom_range(0, 9), 0, 32'h0, est, edat, ecyc, eatt);
      begin
        int          d;
        logic [31:0] rdat;
        d    = $urandom_range(0, 9);
        rdat = $urandom;
        model(we, term, d, 0, rdat, est, edat, ecyc, eatt);
        run_cmd($sformatf("rnd%0d", i), we, 16'($urandom), $urandom, 4'($urandom), term, d, 0,
                rdat, $urandom_range(0, 3), est, edat, ecyc, eatt);
      end
    end

`ifdef WBM_CMD_RETRY_EN
    model(1'b0, 1, 0, 5, 32'h0BADF00D, est, edat, ecyc, eatt);
    run_cmd("rty_exhaust", 1'b0, 16'h4000, 32'h0, 4'hF, 1, 0, 5, 32'h0BADF00D, 0, est, edat, ecyc, eatt);
    model(1'b0, 1, 0, 2, 32'h600DF00D, est, edat, ecyc, eatt);
    run_cmd("rty_then_ack", 1'b0, 16'h4004, 32'h0, 4'hF, 1, 0, 2, 32'h600DF00D, 0, est, edat, ecyc, eatt);
`endif

    // back-to-back throughput: ack on the first stb cycle, response always taken
    acc = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 16'h0100; rsp_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (cmd_ready) acc++;
      wb_ack = wb_cyc;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wb_ack = wb_cyc;
      @(negedge clk);
    end
    wb_ack = 1'b0; rsp_ready = 1'b0;
    check("throughput_accepts", acc, 10);

    // asynchronous reset in the middle of a bus cycle
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 16'h00AA;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("mid_cycle_cyc", wb_cyc, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {wb_cyc, wb_stb, wb_we, wb_adr, wb_wdat, wb_sel, rsp_valid, rsp_dat, rsp_status, busy, cmd_ready},
          '0);
    @(negedge clk);
    rst_n = 1'b1;
    zr = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid || wb_cyc) zr++;
      @(negedge clk);
    end
    check("no_rsp_after_reset", zr, 0);
    run_cmd("post_reset", 1'b0, 16'h0BEE, 32'h0, 4'hF, 1, 0, 0, 32'h13579BDF, 0,
            2'b00, 32'h13579BDF, 1, 1);

    // timeout disabled: cyc stays up indefinitely and no response appears
    @(negedge clk);
    z_cmd_valid = 1'b1;
    @(negedge clk);
    z_cmd_valid = 1'b0;
    zc = 0; zr = 0;
    for (int i = 0; i < 1000; i++) begin
      if (z_cyc && z_stb && z_adr == 16'h0042) zc++;
      if (z_rsp_valid) zr++;
      @(negedge clk);
    end
    check("nto_cyc_held", zc, 1000);
    check("nto_no_rsp", zr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global watchdog so the bench always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
